// File: rtl/multiple_ram_rd.sv
// multiple_ram_rd: single-word readback from one of 16 DPRAMs; define MULTIPLE_RAM_RD_HOLD_EN to hold Data_out between captures
module multiple_ram_rd #(
  parameter int RD_LATENCY = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [3:0]   RAM_sel,
  input  logic [12:0]  Addr_in,
  input  logic         Read_in,
  input  logic [511:0] ram_rd_data,
  output logic [12:0]  Ram_Addr,
  output logic [15:0]  ram_cs,
  output logic         ram_rd_en,
  output logic [31:0]  Data_out,
  output logic         rd_valid,
  output logic         busy,
  output logic         rd_overrun
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CAPTURE} state_t;
  state_t state_q, state_d;
  logic [3:0] sel_q, sel_d;
  logic [12:0] addr_q, addr_d;
  logic [2:0] cnt_q, cnt_d;
  logic [31:0] data_q, data_d;
  logic rd_prev_q, ovr_q, ovr_d, rd_edge;
  assign rd_edge = Read_in & ~rd_prev_q;
  // Request tracking; a request landing outside IDLE is dropped and only flagged
  always_comb begin
    state_d = state_q;
    sel_d = sel_q;
    addr_d = addr_q;
    cnt_d = cnt_q;
    data_d = data_q;
    ovr_d = ovr_q | (rd_edge && state_q != IDLE);
    case (state_q)
      IDLE: if (rd_edge) begin
        sel_d = RAM_sel;
        addr_d = Addr_in;
        ovr_d = 1'b0;
        state_d = ISSUE;
      end
      ISSUE: begin
        cnt_d = 3'(RD_LATENCY - 1);
        state_d = WAIT;
      end
      WAIT: if (cnt_q == 3'd0) begin
        data_d = ram_rd_data[{sel_q, 5'd0} +: 32];
        state_d = CAPTURE;
      end else begin
        cnt_d = cnt_q - 3'd1;
      end
      CAPTURE: state_d = IDLE;
    endcase
  end
  // State registers; rd_prev resets high so a level held across reset is not an edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      sel_q <= '0;
      addr_q <= '0;
      cnt_q <= '0;
      data_q <= '0;
      ovr_q <= 1'b0;
      rd_prev_q <= 1'b1;
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      addr_q <= addr_d;
      cnt_q <= cnt_d;
      data_q <= data_d;
      ovr_q <= ovr_d;
      rd_prev_q <= Read_in;
    end
  end
  assign ram_rd_en = state_q == ISSUE;
  assign ram_cs = ram_rd_en ? 16'd1 << sel_q : 16'd0;
  assign rd_valid = state_q == CAPTURE;
  assign busy = state_q != IDLE;
  assign Ram_Addr = addr_q;
  assign rd_overrun = ovr_q;
`ifdef MULTIPLE_RAM_RD_HOLD_EN
  assign Data_out = data_q;
`else
  assign Data_out = rd_valid ? data_q : 32'd0;
`endif
endmodule

// File: tb/tb_multiple_ram_rd.sv
// tb_multiple_ram_rd: three DUTs (RD_LATENCY 1, 2, 7) on shared random stimulus, checked against a timeline model
module tb_multiple_ram_rd;
`ifdef MULTIPLE_RAM_RD_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset;
  logic [3:0] ram_sel;
  logic [12:0] addr_in;
  logic read_in;
  logic [511:0] rd_data;
  logic [12:0] addr_o [3];
  logic [15:0] cs_o [3];
  logic rden_o [3];
  logic [31:0] dout_o [3];
  logic valid_o [3];
  logic busy_o [3];
  logic ovr_o [3];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit m_act [3];
  int m_n [3];
  logic [3:0] m_sel [3];
  logic [12:0] m_addr [3];
  logic m_ovr [3];
  logic m_prev [3];
  logic [31:0] m_hold [3];
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    multiple_ram_rd #(.RD_LATENCY(g == 0 ? 1 : g == 1 ? 2 : 7)) u_dut (
      .clk(clk), .reset(reset), .RAM_sel(ram_sel), .Addr_in(addr_in), .Read_in(read_in),
      .ram_rd_data(rd_data), .Ram_Addr(addr_o[g]), .ram_cs(cs_o[g]), .ram_rd_en(rden_o[g]),
      .Data_out(dout_o[g]), .rd_valid(valid_o[g]), .busy(busy_o[g]), .rd_overrun(ovr_o[g])
    );
  end
  function automatic int lat(int l);
    return l == 0 ? 1 : l == 1 ? 2 : 7;
  endfunction
  task automatic chk(string nm, int l, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s lane%0d cycle %0d got %h want %h", nm, l, cyc, act, exp);
    end
  endtask
  // Model: a read accepted at offset 0 strobes at offset 1, samples data at the end of offset L+1, is valid at L+2
  task automatic model_step();
    for (int l = 0; l < 3; l++) begin
      logic v;
      logic e;
      if (!reset) begin
        m_act[l] = 0; m_n[l] = 0; m_sel[l] = '0; m_addr[l] = '0;
        m_ovr[l] = 1'b0; m_prev[l] = 1'b1; m_hold[l] = '0;
      end
      v = m_act[l] && m_n[l] == lat(l) + 2;
      chk("rd_en", l, 32'(rden_o[l]), 32'(m_act[l] && m_n[l] == 1));
      chk("ram_cs", l, 32'(cs_o[l]), (m_act[l] && m_n[l] == 1) ? 32'd1 << m_sel[l] : 32'd0);
      chk("rd_valid", l, 32'(valid_o[l]), 32'(v));
      chk("busy", l, 32'(busy_o[l]), 32'(m_act[l]));
      chk("Ram_Addr", l, 32'(addr_o[l]), 32'(m_addr[l]));
      chk("overrun", l, 32'(ovr_o[l]), 32'(m_ovr[l]));
      chk("Data_out", l, dout_o[l], (HOLD || v) ? m_hold[l] : 32'd0);
      if (reset) begin
        e = read_in & ~m_prev[l];
        if (m_act[l] && m_n[l] == lat(l) + 1) m_hold[l] = rd_data[32*m_sel[l] +: 32];
        if (e && m_act[l]) m_ovr[l] = 1'b1;
        else if (e) begin
          m_act[l] = 1; m_n[l] = 0; m_sel[l] = ram_sel; m_addr[l] = addr_in; m_ovr[l] = 1'b0;
        end
        if (m_act[l]) m_n[l]++;
        if (m_n[l] > lat(l) + 2) m_act[l] = 0;
        m_prev[l] = read_in;
      end
    end
  endtask
  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic rand_data();
    for (int k = 0; k < 16; k++) rd_data[32*k +: 32] = $urandom;
  endtask
  initial begin
    int nv;
    reset = 1'b0; read_in = 1'b1; ram_sel = '0; addr_in = '0; rd_data = '0;
    tick(); tick();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("lvl_rd_en", 1, 32'(rden_o[1]), 32'd0);
      chk("lvl_busy", 1, 32'(busy_o[1]), 32'd0);
    end
    read_in = 1'b0;
    tick();
    rand_data();
    rd_data[32*5 +: 32] = 32'hDEADBEEF;
    read_in = 1'b1; ram_sel = 4'd5; addr_in = 13'h1A3;
    tick();
    chk("cs_c1", 1, 32'(cs_o[1]), 32'h0020);
    chk("addr_c1", 1, 32'(addr_o[1]), 32'h1A3);
    ram_sel = 4'd0; addr_in = 13'h0;
    tick(); tick();
    chk("valid_c3", 0, 32'(valid_o[0]), 32'd1);
    chk("data_c3", 0, dout_o[0], 32'hDEADBEEF);
    tick();
    chk("valid_c4", 1, 32'(valid_o[1]), 32'd1);
    chk("data_c4", 1, dout_o[1], 32'hDEADBEEF);
    tick();
    chk("data_c5", 1, dout_o[1], HOLD ? 32'hDEADBEEF : 32'd0);
    tick(); tick(); tick(); tick();
    chk("valid_c9", 2, 32'(valid_o[2]), 32'd1);
    tick();
    for (int s = 0; s < 16; s++) begin
      read_in = 1'b0;
      tick();
      rand_data();
      read_in = 1'b1; ram_sel = 4'(s); addr_in = 13'($urandom);
      tick();
      chk("sweep_cs", 1, 32'(cs_o[1]), 32'd1 << s);
      for (int i = 0; i < 10; i++) tick();
    end
    read_in = 1'b0;
    tick();
    read_in = 1'b1;
    tick();
    read_in = 1'b0;
    tick();
    read_in = 1'b1;
    tick();
    chk("ovr_set", 1, 32'(ovr_o[1]), 32'd1);
    nv = 0;
    for (int i = 0; i < 10; i++) begin
      if (valid_o[1]) nv++;
      tick();
    end
    chk("one_valid", 1, 32'(nv), 32'd1);
    read_in = 1'b0;
    tick();
    read_in = 1'b1;
    tick();
    chk("ovr_clr", 1, 32'(ovr_o[1]), 32'd0);
    for (int i = 0; i < 10; i++) tick();
    read_in = 1'b0;
    tick();
    read_in = 1'b1;
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_busy", 1, 32'(busy_o[1]), 32'd0);
    tick();
    reset = 1'b1;
    nv = 0;
    for (int i = 0; i < 12; i++) begin
      if (valid_o[1]) nv++;
      tick();
    end
    chk("no_valid", 1, 32'(nv), 32'd0);
    for (int i = 0; i < 4000; i++) begin
      reset = $urandom_range(0, 599) != 0;
      if ($urandom_range(0, 3) == 0) read_in = ~read_in;
      ram_sel = 4'($urandom);
      addr_in = 13'($urandom);
      rand_data();
      tick();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/multiple_ram_rd.md
# multiple_ram_rd

Readback controller for the Microblaze-to-DPRAM/register bank, the read-side partner of the write chip-select path. It detects a read request from the processor register interface, selects one of 16 RAMs, issues a single read strobe, waits the RAM read latency, captures the selected RAM's output word and returns it with a one-cycle valid pulse. It sits between the Microblaze register interface and the read ports of the same 16 DPRAMs the write path drives.

## Interface
- `RD_LATENCY`, 2: RAM read latency in clocks from the `ram_rd_en` cycle to data valid; legal 1..7.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `RAM_sel`  in  4  RAM index 0..15 to read.
- `Addr_in`  in  13  word address within selected RAM.
- `Read_in`  in  1  read request level; rising edge starts one read.
- `ram_rd_data`  in  512  16 RAM read buses packed; RAM k on bits [32k+31:32k].
- `Ram_Addr`  out  13  address to all RAMs.
- `ram_cs`  out  16  one-hot RAM select, active only during the issue cycle.
- `ram_rd_en`  out  1  read strobe, one cycle per accepted request.
- `Data_out`  out  32  returned read word (signed int32 in software).
- `rd_valid`  out  1  one-cycle pulse, `Data_out` valid.
- `busy`  out  1  high from the cycle after edge acceptance through the `rd_valid` cycle.
- `rd_overrun`  out  1  sticky: a rising edge arrived while busy.

## Operation
- Edge detect: `rd_prev` register samples `Read_in` every clock; reset value 1 (a level held high across reset never triggers). Edge = `Read_in & !rd_prev`.
- States: IDLE, ISSUE, WAIT, CAPTURE.
- IDLE: on edge, register `RAM_sel` -> `sel_q`, `Addr_in` -> `addr_q`, clear `rd_overrun`, go ISSUE. Otherwise stay.
- ISSUE (1 cycle): `ram_rd_en`=1, `ram_cs`=one-hot(`sel_q`), load latency counter with `RD_LATENCY`-1; go WAIT.
- WAIT: decrement counter; when counter=0 on a clock edge, capture `ram_rd_data[32*sel_q +: 32]` into data register, go CAPTURE. With counter loaded `RD_LATENCY`-1, capture occurs on the edge ending cycle ISSUE+`RD_LATENCY`.
- CAPTURE (1 cycle): `rd_valid`=1; go IDLE.
- `Ram_Addr` = `addr_q` at all times (holds last address).
- `ram_cs` = 0 and `ram_rd_en` = 0 outside ISSUE.
- Edge while state != IDLE: request dropped (not queued), `rd_overrun` set to 1; stays set until next accepted edge.
- Edge in CAPTURE cycle: dropped and flagged (no back-to-back acceptance).
- `busy` = (state != IDLE).
- Reset (any time, including mid-read): state IDLE, all outputs 0 except `rd_prev`=1; in-flight read abandoned, no `rd_valid`.

## Timing
- Edge detected in cycle 0 -> ISSUE cycle 1 -> WAIT cycles 2..1+`RD_LATENCY` -> CAPTURE cycle 2+`RD_LATENCY`.
- Default `RD_LATENCY`=2: `ram_rd_en` in cycle 1, RAM data sampled at end of cycle 3, `rd_valid` in cycle 4.
- Minimum spacing between accepted requests: `RD_LATENCY`+3 cycles.
- `RAM_sel`/`Addr_in` only need be stable in the edge cycle.

## Configuration
- `MULTIPLE_RAM_RD_HOLD_EN` defined: `Data_out` holds the last captured word until the next capture; reset value 0.
- Not defined: `Data_out` = captured word only while `rd_valid`=1, else 0 (same gating as the write data path).

## Test plan
- Reset release with `Read_in` held 1 -> no `ram_rd_en`, all outputs 0, `busy`=0.
- `RAM_sel`=5, `Addr_in`=0x1A3, RAM5 returns 0xDEADBEEF, `RD_LATENCY`=2 -> `ram_cs`=0x0020 and `Ram_Addr`=0x1A3 in cycle 1, `rd_valid` with `Data_out`=0xDEADBEEF in cycle 4.
- Sweep `RAM_sel` 0..15 with distinct per-RAM data -> correct word each time; `ram_cs` one-hot matches; `RD_LATENCY`=1 and 7 give `rd_valid` at cycles 3 and 9.
- Second edge at cycle 2 of a read -> dropped, `rd_overrun`=1, only one `rd_valid`; next accepted edge clears `rd_overrun`.
- Reset asserted in WAIT -> immediate IDLE, outputs 0, no `rd_valid` after release.
- Cycle after `rd_valid`: `Data_out` retains 0xDEADBEEF with `MULTIPLE_RAM_RD_HOLD_EN`, returns 0 without.
